sobel_window_grad: RTL

Downstream stage of the NTSC Sobel front end: consumes the 8-bit grayscale pixel stream and line/frame markers in the camera `vclk` domain. It builds a 3x3 neighbourhood from two line buffers, computes Sobel Gx/Gy and the magnitude |Gx|+|Gy|, and emits one edge pixel per interior input pixel with its coordinates. The output feeds the frame-buffer writer and display path.

---
 rtl/sobel_window_grad.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_window_grad.sv
// -----------------------------------------------------------------------------
// sobel_window_grad
//
// Purpose:
//   Takes the 8-bit grayscale pixel stream of one video field, keeps the two
//   previous lines in line buffers, assembles a 3x3 neighbourhood and runs a
//   Sobel operator on it. For every interior pixel (column >= 2, row >= 2 of
//   the incoming stream) one edge pixel is produced, tagged with the
//   coordinates of the window centre. Latency is a fixed 3 cycles with one
//   pixel per cycle throughput and no backpressure.
//
// Parameters:
//   WIDTH   active pixels per line (line-buffer depth)
//   THRESH  edge threshold, compared against the 11-bit magnitude
//   BINARY  1: output 0x00/0xFF by threshold, 0: magnitude saturated to 255
//
// Ports:
//   vclk         video clock, all logic on its rising edge
//   reset        synchronous, active-high
//   frame_start  one-cycle pulse, next line becomes row 0
//   line_start   one-cycle pulse ahead of the first pixel of a line
//   pix_valid    qualifies pix_in
//   pix_in       8-bit grayscale pixel
//   edge_valid   qualifies edge_pixel / edge_col / edge_row
//   edge_pixel   edge result
//   edge_col     column of the window centre
//   edge_row     row of the window centre
// -----------------------------------------------------------------------------
module sobel_window_grad #(
    parameter int         WIDTH  = 720,
    parameter logic [7:0] THRESH = 8'd64,
    parameter bit         BINARY = 1'b1
) (
    input  logic       vclk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic       pix_valid,
    input  logic [7:0] pix_in,
    output logic       edge_valid,
    output logic [7:0] edge_pixel,
    output logic [9:0] edge_col,
    output logic [9:0] edge_row
);

    localparam int         AW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [9:0] LAST_X = 10'(WIDTH);
    localparam logic [9:0] MAX_Y  = 10'd1023;

    // -------------------------------------------------------------------------
    // Position tracking
    // -------------------------------------------------------------------------
    logic [9:0]    x;
    logic [9:0]    y;
    logic          first_line;

    logic [9:0]    x_cur;
    logic [9:0]    y_cur;
    logic          first_cur;
    logic          accept;
    logic [AW-1:0] addr;

    // Markers take effect in the same cycle they arrive, so a pixel sharing
    // a cycle with line_start (and frame_start) already sees the new
    // column/row. frame_start arms first_line so that the following
    // line_start lands on row 0 instead of incrementing.
    always_comb begin
        x_cur     = line_start ? 10'd0 : x;
        y_cur     = y;
        first_cur = first_line;
        if (frame_start) begin
            y_cur     = 10'd0;
            first_cur = 1'b1;
        end
        if (line_start) begin
            if (first_cur) begin
                first_cur = 1'b0;
            end else if (y_cur != MAX_Y) begin
                y_cur = y_cur + 10'd1;
            end
        end
        // Pixels beyond the end of the line are ignored entirely.
        accept = pix_valid && (x_cur < LAST_X);
        addr   = x_cur[AW-1:0];
    end

    always_ff @(posedge vclk) begin
        if (reset) begin
            x          <= 10'd0;
            y          <= 10'd0;
            first_line <= 1'b1;
        end else begin
            x          <= accept ? (x_cur + 10'd1) : x_cur;
            y          <= y_cur;
            first_line <= first_cur;
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers
    // -------------------------------------------------------------------------
    // lb0 holds the previous line, lb1 the one before it. On each accepted
    // pixel the column ripples upward: lb0 -> lb1, new pixel -> lb0. The
    // contents are deliberately not reset; the row >= 2 qualification keeps
    // stale lines from ever reaching the output.
    logic [7:0] lb0 [WIDTH];
    logic [7:0] lb1 [WIDTH];
    logic [7:0] col_top;
    logic [7:0] col_mid;

    assign col_top = lb1[addr];
    assign col_mid = lb0[addr];

    always_ff @(posedge vclk) begin
        if (accept) begin
            lb1[addr] <= lb0[addr];
            lb0[addr] <= pix_in;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: 3x3 window
    // -------------------------------------------------------------------------
    // Index 0 is the oldest column, index 2 the newest. The window only moves
    // on accepted pixels, so gaps in pix_valid do not disturb it.
    logic [7:0] win_top [3];
    logic [7:0] win_mid [3];
    logic [7:0] win_bot [3];
    logic       s1_valid;
    logic [9:0] s1_col;
    logic [9:0] s1_row;

    always_ff @(posedge vclk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_col   <= 10'd0;
            s1_row   <= 10'd0;
            for (int i = 0; i < 3; i++) begin
                win_top[i] <= 8'd0;
                win_mid[i] <= 8'd0;
                win_bot[i] <= 8'd0;
            end
        end else begin
            s1_valid <= accept && (x_cur >= 10'd2) && (y_cur >= 10'd2);
            if (accept) begin
                win_top[0] <= win_top[1];
                win_top[1] <= win_top[2];
                win_top[2] <= col_top;
                win_mid[0] <= win_mid[1];
                win_mid[1] <= win_mid[2];
                win_mid[2] <= col_mid;
                win_bot[0] <= win_bot[1];
                win_bot[1] <= win_bot[2];
                win_bot[2] <= pix_in;
                // The newest column is at x, so the centre sits one back.
                s1_col     <= x_cur - 10'd1;
                s1_row     <= y_cur - 10'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: gradients
    // -------------------------------------------------------------------------
    // Weighted 1-2-1 sum of three pixels, at most 1020, so 11 bits hold it
    // and the signed difference of two such sums never wraps.
    function automatic logic [10:0] weigh(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    logic signed [10:0] gx_comb;
    logic signed [10:0] gy_comb;
    logic signed [10:0] s2_gx;
    logic signed [10:0] s2_gy;
    logic               s2_valid;
    logic [9:0]         s2_col;
    logic [9:0]         s2_row;

    always_comb begin
        gx_comb = $signed(weigh(win_top[2], win_mid[2], win_bot[2]))
                - $signed(weigh(win_top[0], win_mid[0], win_bot[0]));
        gy_comb = $signed(weigh(win_bot[0], win_bot[1], win_bot[2]))
                - $signed(weigh(win_top[0], win_top[1], win_top[2]));
    end

    always_ff @(posedge vclk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_gx    <= 11'sd0;
            s2_gy    <= 11'sd0;
            s2_col   <= 10'd0;
            s2_row   <= 10'd0;
        end else begin
            s2_valid <= s1_valid;
            s2_gx    <= gx_comb;
            s2_gy    <= gy_comb;
            s2_col   <= s1_col;
            s2_row   <= s1_row;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: magnitude and output
    // -------------------------------------------------------------------------
    // |Gx| and |Gy| are each at most 1020, so their sum fits 11 bits.
    logic [10:0] abs_x;
    logic [10:0] abs_y;
    logic [10:0] mag;
    logic [7:0]  result;

    always_comb begin
        abs_x = s2_gx[10] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
        abs_y = s2_gy[10] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
        mag   = abs_x + abs_y;
        if (BINARY) begin
            result = (mag >= {3'b000, THRESH}) ? 8'hFF : 8'h00;
        end else begin
            result = (mag > 11'd255) ? 8'hFF : mag[7:0];
        end
    end

    // Data outputs only update with a valid result, so they hold between
    // results.
    always_ff @(posedge vclk) begin
        if (reset) begin
            edge_valid <= 1'b0;
            edge_pixel <= 8'd0;
            edge_col   <= 10'd0;
            edge_row   <= 10'd0;
        end else begin
            edge_valid <= s2_valid;
            if (s2_valid) begin
                edge_pixel <= result;
                edge_col   <= s2_col;
                edge_row   <= s2_row;
            end
        end
    end

endmodule
